// File: rtl/cordic_multiply.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cordic_multiply: iterative linear-mode CORDIC signed fixed-point multiply |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module cordic_multiply #(
  parameter int WL     = 16,
  parameter int FL     = 14,
  parameter int N_ITER = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic signed [WL-1:0] in1,
  input  logic signed [WL-1:0] in2,
  output logic signed [WL-1:0] out,
  output logic                 done
);

  localparam int AW = WL + 2;
  localparam int IW = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [IW-1:0] LAST_ITER = IW'(N_ITER - 1);
  localparam logic [AW-1:0] ONE       = AW'(1);
  localparam logic [WL-1:0] SAT_MAX   = {1'b0, {(WL-1){1'b1}}};
  localparam logic [WL-1:0] SAT_MIN   = {1'b1, {(WL-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic signed [WL-1:0]  x_q, x_d;
  logic signed [AW-1:0]  y_q, y_d;
  logic signed [AW-1:0]  z_q, z_d;
  logic        [IW-1:0]  i_q, i_d;
  logic signed [WL-1:0]  out_q, out_d;
  logic                  done_q, done_d;

  logic signed [AW-1:0]  x_ext;
  logic signed [AW-1:0]  x_shift;
  logic signed [AW-1:0]  z_step;
  logic signed [WL-1:0]  y_sat;

  always_comb begin
    x_ext   = {{2{x_q[WL-1]}}, x_q};
    x_shift = x_ext >>> i_q;
    z_step  = ONE << (FL - int'(i_q));
  end

  // The product fits in WL bits only when the bits above the sign agree.
  always_comb begin
    if ((y_q[AW-1:WL-1] == '0) || (y_q[AW-1:WL-1] == '1)) begin
      y_sat = y_q[WL-1:0];
    end else if (y_q[AW-1]) begin
      y_sat = SAT_MIN;
    end else begin
      y_sat = SAT_MAX;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    out_d   = out_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = in1;
          y_d     = '0;
          z_d     = {{2{in2[WL-1]}}, in2};
          i_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // d = +1 while z is non-negative, otherwise -1.
        if (!z_q[AW-1]) begin
          y_d = y_q + x_shift;
          z_d = z_q - z_step;
        end else begin
          y_d = y_q - x_shift;
          z_d = z_q + z_step;
        end
        i_d = i_q + IW'(1);
        if (i_q == LAST_ITER) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_d   = y_sat;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_multiply.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cordic_multiply: directed self-checking bench for cordic_multiply      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_cordic_multiply;

  localparam int WL      = 16;
  localparam int FL      = 14;
  localparam int N_ITER  = 15;
  localparam int LATENCY = N_ITER + 1;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic signed [WL-1:0] in1;
  logic signed [WL-1:0] in2;
  logic signed [WL-1:0] out;
  logic                 done;

  int checks = 0;
  int errors = 0;

  cordic_multiply #(.WL(WL), .FL(FL), .N_ITER(N_ITER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .out   (out),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and watch a fixed window after the capture edge.
  // lat is the cycle count of the first done (0 if none), res is out then.
  task automatic do_op(input logic [WL-1:0] a, input logic [WL-1:0] b,
                       output logic signed [WL-1:0] res, output int lat,
                       output int pulses);
    res    = '0;
    lat    = 0;
    pulses = 0;
    in1    = a;
    in2    = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    in1   = ~a;
    in2   = ~b;
    for (int c = 1; c <= LATENCY + 6; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        if (lat == 0) begin
          lat = c;
          res = out;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    in1   = '0;
    in2   = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out !== 16'sd0) begin
      errors++;
      $display("FAIL reset_out: got %0d expected 0", out);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b expected 0", done);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero;
    logic signed [WL-1:0] res;
    int lat, pulses;
    do_op(16'h0000, 16'h3000, res, lat, pulses);
    checks++;
    if (res !== 16'sd0) begin
      errors++;
      $display("FAIL zero_out: got %0d expected 0", res);
    end
    checks++;
    if (lat !== LATENCY) begin
      errors++;
      $display("FAIL zero_latency: got %0d expected %0d", lat, LATENCY);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL zero_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_positive;
    logic signed [WL-1:0] res;
    int lat, pulses, diff;
    do_op(16'h2000, 16'h2000, res, lat, pulses);
    diff = int'(res) - 4096;
    checks++;
    if (lat == 0 || diff > 4 || diff < -4) begin
      errors++;
      $display("FAIL pos_product: got %0d expected 4096 +/-4", res);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL pos_pulses: got %0d expected 1", pulses);
    end
    checks++;
    if (lat !== LATENCY) begin
      errors++;
      $display("FAIL pos_latency: got %0d expected %0d", lat, LATENCY);
    end
  endtask

  task automatic test_negative;
    logic signed [WL-1:0] res;
    int lat, pulses, diff;
    do_op(16'h2000, 16'hE000, res, lat, pulses);
    diff = int'(res) + 4096;
    checks++;
    if (lat == 0 || diff > 4 || diff < -4) begin
      errors++;
      $display("FAIL neg_product: got %0d expected -4096 +/-4", res);
    end
    // 1.0 * 0.75 exercises a non-power-of-two multiplier.
    do_op(16'h4000, 16'h3000, res, lat, pulses);
    diff = int'(res) - 12288;
    checks++;
    if (lat == 0 || diff > 4 || diff < -4) begin
      errors++;
      $display("FAIL mixed_product: got %0d expected 12288 +/-4", res);
    end
  endtask

  task automatic test_saturation;
    logic signed [WL-1:0] res;
    int lat, pulses;
    do_op(16'h7FFF, 16'h7FFF, res, lat, pulses);
    checks++;
    if (lat == 0 || res !== 16'sh7FFF) begin
      errors++;
      $display("FAIL pos_sat: got %0d expected 32767", res);
    end
    do_op(16'h7FFF, 16'h8001, res, lat, pulses);
    checks++;
    if (lat == 0 || res !== 16'sh8000) begin
      errors++;
      $display("FAIL neg_sat: got %0d expected -32768", res);
    end
    checks++;
    if (out !== 16'sh8000) begin
      errors++;
      $display("FAIL out_hold: got %0d expected -32768", out);
    end
  endtask

  task automatic test_start_busy;
    logic signed [WL-1:0] res;
    int lat, pulses, diff;
    res    = '0;
    lat    = 0;
    pulses = 0;
    in1    = 16'h2000;
    in2    = 16'h2000;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 2 * LATENCY + 6; c++) begin
      if (c == 5) begin
        in1   = 16'h7FFF;
        in2   = 16'h8001;
        start = 1'b1;
      end
      if (c == 7) start = 1'b0;
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        if (lat == 0) begin
          lat = c;
          res = out;
        end
      end
    end
    diff = int'(res) - 4096;
    checks++;
    if (lat == 0 || diff > 4 || diff < -4) begin
      errors++;
      $display("FAIL busy_result: got %0d expected 4096 +/-4", res);
    end
    checks++;
    if (lat !== LATENCY) begin
      errors++;
      $display("FAIL busy_latency: got %0d expected %0d", lat, LATENCY);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL busy_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_abort_reset;
    logic signed [WL-1:0] res;
    int lat, pulses, diff;
    in1   = 16'h2000;
    in2   = 16'h2000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 16'sd0) begin
      errors++;
      $display("FAIL abort_out: got %0d expected 0", out);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL abort_done: got %b expected 0", done);
    end
    @(posedge clk);
    #3;
    rst_n  = 1'b1;
    pulses = 0;
    for (int c = 0; c < LATENCY + 8; c++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d pulses expected 0", pulses);
    end
    do_op(16'h4000, 16'hC000, res, lat, pulses);
    diff = int'(res) + 16384;
    checks++;
    if (lat == 0 || diff > 4 || diff < -4) begin
      errors++;
      $display("FAIL restart_product: got %0d expected -16384 +/-4", res);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_positive();
    test_negative();
    test_saturation();
    test_start_busy();
    test_abort_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cordic_multiply.md
# cordic_multiply

Iterative linear-mode CORDIC multiplier for signed fixed-point operands. On a start pulse it captures two signed WL-bit operands and performs N_ITER shift-add iterations, one per clock, driving z (= in2) toward zero while accumulating y += d·(in1 >> i). The saturated signed WL-bit product is presented on out, with a one-cycle done pulse. It is a small, multiplier-free arithmetic unit for datapaths that cannot spare a hardware multiplier.

## Interface
- WL, default 16: word length of operands and result (two's complement).
- FL, default 14: fraction bits; default format is Q2.14, range [-2, 2).
- N_ITER, default 15: CORDIC iterations. Must satisfy N_ITER ≤ FL+1.
- clk  input  1  rising-edge clock; the block has one clock only.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled high in IDLE captures the operands.
- in1  input  WL  signed multiplicand x, in Q(WL-FL).FL format.
- in2  input  WL  signed multiplier z, in Q(WL-FL).FL format.
- out  output  WL  signed product in1·in2, same Q format, saturated.
- done  output  1  one-cycle pulse marking a new valid out.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE, start=1:**
  - x ← in1, y ← 0, z ← in2 (z sign-extended to WL+2 bits), i ← 0.
  - Go to RUN.
- **IDLE, start=0:** hold.
- **RUN, each cycle, iteration i:**
  - d = +1 if z ≥ 0, else −1.
  - y ← y + d·(x >>> i), using an arithmetic shift with truncation.
  - z ← z − d·(1 << (FL−i)).
  - i ← i+1.
  - After iteration i = N_ITER−1, go to DONE.
- **DONE, one cycle:**
  - out ← sat(y), done ← 1.
  - Go to IDLE.
- **Widths:** y and z accumulators are WL+2 bits signed, so intermediate results up to ±4.0 do not wrap.
- **Saturation:**
  - sat(y) clamps to [−2^(WL−1), 2^(WL−1)−1]; defaults [−32768, 32767].
  - Otherwise sat(y) is y[WL−1:0].
- **Accuracy:**
  - Convergence holds for |in2| < 2 (Σ2^−i).
  - Result error ≤ ±4 LSB of the ideal truncated product (in1·in2) >> FL before saturation.
- **Operand capture:** in1/in2 are only sampled at the capture edge; later changes have no effect on the running operation.
- **Start while busy:** start in RUN or DONE is ignored; it is not queued.
- **Output hold:** out holds its last value until the next DONE cycle. done is low in all cycles except the one following the DONE edge.

## Timing
- **Reset:** asynchronous assertion forces state IDLE, out=0, done=0, and clears x, y, z and i. This also aborts any operation in progress; no done is issued for it.
- **Release:** takes effect on the next rising clk edge.
- **Latency:**
  - Capture at edge k.
  - Iterations at edges k+1 … k+N_ITER.
  - out updated and done=1 at edge k+N_ITER+1; done deasserts at edge k+N_ITER+2.
  - With defaults, done rises 16 cycles after the capture edge.
- **Throughput:** one operation per N_ITER+2 cycles. The earliest next capture is the edge after done rises, i.e. start sampled at edge k+N_ITER+2.
- **Start width:** a start held high for several cycles triggers only one operation, provided it is low again by the time IDLE is re-entered. Otherwise a new operation starts.

## Test plan
- **Zero operand:** reset, then in1=0, in2=0x3000 (0.75), start for 1 cycle -> done pulse 16 cycles after capture; out=0.
- **Positive product:** in1=in2=0x2000 (0.5) -> out within ±4 of 4096 (0.25); done high exactly one cycle.
- **Negative product:** in1=0x2000, in2=−0x2000 (0xE000) -> out within ±4 of −4096.
- **Positive saturation:** in1=in2=0x7FFF (≈1.9999) -> ideal product ≈3.9998 overflows; out=32767 (0x7FFF).
- **Negative saturation:** in1=0x7FFF, in2=−0x7FFF (0x8001) -> out=−32768 (0x8000).
- **Control robustness:**
  - Pulse start again mid-RUN with different operands -> ignored; the first result is unchanged.
  - Assert rst_n=0 mid-RUN -> out=0, done=0 immediately, no done pulse follows.
  - A fresh start after release computes correctly.
